// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core: FSM encoding, segment patterns,
// BCD time record and its increment with minute/second/centisecond carries.
package stopwatch_pkg;

    localparam int unsigned TICKS_PER_CS_DEFAULT = 500000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_LAP   = 2'd3;

    localparam logic [3:0] DIGIT_MAX_9 = 4'd9;
    localparam logic [3:0] DIGIT_MAX_5 = 4'd5;

    // Active-low, bit0 = segment a ... bit6 = segment g
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef struct packed {
        logic [3:0] min_t;
        logic [3:0] min_o;
        logic [3:0] sec_t;
        logic [3:0] sec_o;
        logic [3:0] cs_t;
        logic [3:0] cs_o;
    } bcd_time_t;

    localparam bcd_time_t TIME_ZERO = '0;

    function automatic bcd_time_t bcd_time_inc(input bcd_time_t t);
        bcd_time_t r;
        r = t;
        if (t.cs_o != DIGIT_MAX_9) begin
            r.cs_o = t.cs_o + 4'd1;
        end else begin
            r.cs_o = '0;
            if (t.cs_t != DIGIT_MAX_9) begin
                r.cs_t = t.cs_t + 4'd1;
            end else begin
                r.cs_t = '0;
                if (t.sec_o != DIGIT_MAX_9) begin
                    r.sec_o = t.sec_o + 4'd1;
                end else begin
                    r.sec_o = '0;
                    if (t.sec_t != DIGIT_MAX_5) begin
                        r.sec_t = t.sec_t + 4'd1;
                    end else begin
                        r.sec_t = '0;
                        if (t.min_o != DIGIT_MAX_9) begin
                            r.min_o = t.min_o + 4'd1;
                        end else begin
                            r.min_o = '0;
                            r.min_t = (t.min_t != DIGIT_MAX_5) ? t.min_t + 4'd1 : 4'd0;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-low 7-segment pattern; non-BCD blanks.
module bcd_to_seg7
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_OFF;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: run/pause/lap FSM, centisecond prescaler, MM:SS.CC BCD
// count with lap freeze, and registered 7-segment outputs.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS_PER_CS = TICKS_PER_CS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [6:0] stop_disp0,
    output logic [6:0] stop_disp1,
    output logic [6:0] stop_disp2,
    output logic [6:0] stop_disp3,
    output logic [6:0] stop_disp4,
    output logic [6:0] stop_disp5,
    output logic       running
);

    localparam int unsigned PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_CS - 1);

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    bcd_time_t     count_q, count_d;
    bcd_time_t     lap_q, lap_d;
    bcd_time_t     count_cur;
    bcd_time_t     disp_src;
    logic          counting;
    logic          tick;
    logic [3:0]    src_dig [6];
    logic [6:0]    seg_d   [6];
    logic [6:0]    disp_q  [6];

    // Live count as seen by increment, lap capture and display selection
    assign count_cur = count_q;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (presc_q == PRESC_MAX);
    assign running  = counting;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_cur;
        lap_d   = lap_q;

        // Increment applies even when start_stop leaves RUN/LAP on this edge
        if (counting) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                count_d = bcd_time_inc(count_cur);
            end
        end

        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = ST_LAP;
                    lap_d   = count_cur;
                end
            end
            ST_LAP: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    count_d = TIME_ZERO;
                    presc_d = '0;
                end else if (start_stop) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign disp_src = (state_q == ST_LAP) ? lap_q : count_cur;

    always_comb begin
        src_dig[0] = disp_src.cs_o;
        src_dig[1] = disp_src.cs_t;
        src_dig[2] = disp_src.sec_o;
        src_dig[3] = disp_src.sec_t;
        src_dig[4] = disp_src.min_o;
        src_dig[5] = disp_src.min_t;
    end

    for (genvar g = 0; g < 6; g++) begin : g_seg
        bcd_to_seg7 u_seg (
            .bcd_i (src_dig[g]),
            .seg_o (seg_d[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= TIME_ZERO;
            lap_q   <= TIME_ZERO;
            for (int unsigned i = 0; i < 6; i++) begin
                disp_q[i] <= SEG_0;
            end
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            lap_q   <= lap_d;
            for (int unsigned i = 0; i < 6; i++) begin
                disp_q[i] <= seg_d[i];
            end
        end
    end

    assign stop_disp0 = disp_q[0];
    assign stop_disp1 = disp_q[1];
    assign stop_disp2 = disp_q[2];
    assign stop_disp3 = disp_q[3];
    assign stop_disp4 = disp_q[4];
    assign stop_disp5 = disp_q[5];

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed self-checking bench for stopwatch_core with TICKS_PER_CS = 4.
module tb_stopwatch_core;
    import stopwatch_pkg::*;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P9 = 7'b0010000;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [6:0] stop_disp0, stop_disp1, stop_disp2, stop_disp3, stop_disp4, stop_disp5;
    logic       running;

    int n_cmp;
    int n_err;

    stopwatch_core #(.TICKS_PER_CS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .stop_disp0 (stop_disp0),
        .stop_disp1 (stop_disp1),
        .stop_disp2 (stop_disp2),
        .stop_disp3 (stop_disp3),
        .stop_disp4 (stop_disp4),
        .stop_disp5 (stop_disp5),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [41:0] disp_all();
        return {stop_disp5, stop_disp4, stop_disp3, stop_disp2, stop_disp1, stop_disp0};
    endfunction

    // Called at a negedge; the pulse is seen by exactly one rising edge.
    task automatic pulse(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_stop = 1'b1;
        clear = 1'b1;
        lap = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (running !== 1'b0) begin
            n_err++; $display("FAIL reset_running: got %b want 0", running);
        end
        n_cmp++;
        if (disp_all() !== {6{P0}}) begin
            n_err++; $display("FAIL reset_disp: got %h want %h", disp_all(), {6{P0}});
        end
        n_cmp++;
        if (dut.count_q !== 24'h000000 || dut.state_q !== ST_IDLE) begin
            n_err++; $display("FAIL reset_state: count %h state %0d want 000000 / IDLE", dut.count_q, dut.state_q);
        end
        reset = 1'b0;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_run_basic();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        n_cmp++;
        if (running !== 1'b1) begin
            n_err++; $display("FAIL run_running: got %b want 1", running);
        end
        n_cmp++;
        if (dut.count_q !== 24'h000010) begin
            n_err++; $display("FAIL run_count: got %h want 000010", dut.count_q);
        end
        n_cmp++;
        if (disp_all() !== {P0, P0, P0, P0, P0, P9}) begin
            n_err++; $display("FAIL run_disp_lag: got %h want %h", disp_all(), {P0, P0, P0, P0, P0, P9});
        end
        @(negedge clk);
        n_cmp++;
        if (stop_disp1 !== 7'b1111001 || stop_disp0 !== 7'b1000000) begin
            n_err++; $display("FAIL run_disp: got d1=%b d0=%b want 1111001 1000000", stop_disp1, stop_disp0);
        end
    endtask

    task automatic test_wrap();
        int waited;
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        waited = 0;
        while (dut.presc_q !== 2'd3 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (dut.presc_q !== 2'd3) begin
            n_err++; $display("FAIL wrap_presc_wait: got %0d want 3", dut.presc_q);
        end else begin
            force dut.count_cur = 24'h595999;
            @(posedge clk);
            #1;
            release dut.count_cur;
            n_cmp++;
            if (dut.count_q !== 24'h000000 || dut.state_q !== ST_RUN) begin
                n_err++; $display("FAIL wrap_count: count %h state %0d want 000000 / RUN", dut.count_q, dut.state_q);
            end
            @(negedge clk);
            n_cmp++;
            if (disp_all() !== {P5, P9, P5, P9, P9, P9}) begin
                n_err++; $display("FAIL wrap_preload_disp: got %h want %h", disp_all(), {P5, P9, P5, P9, P9, P9});
            end
            @(negedge clk);
            n_cmp++;
            if (disp_all() !== {6{P0}} || running !== 1'b1) begin
                n_err++; $display("FAIL wrap_disp: got %h run %b want %h run 1", disp_all(), running, {6{P0}});
            end
        end
    endtask

    task automatic test_lap();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000005) begin
            n_err++; $display("FAIL lap_precount: got %h want 000005", dut.count_q);
        end
        pulse(1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000010 || running !== 1'b1) begin
            n_err++; $display("FAIL lap_count: count %h run %b want 000010 run 1", dut.count_q, running);
        end
        n_cmp++;
        if (disp_all() !== {P0, P0, P0, P0, P0, P5}) begin
            n_err++; $display("FAIL lap_frozen_disp: got %h want %h", disp_all(), {P0, P0, P0, P0, P0, P5});
        end
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (disp_all() !== {P0, P0, P0, P0, P1, P0} || dut.state_q !== ST_RUN) begin
            n_err++; $display("FAIL lap_release_disp: got %h state %0d want %h RUN", disp_all(), dut.state_q, {P0, P0, P0, P0, P1, P0});
        end
    endtask

    task automatic test_pause_clear();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (28) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000007 || dut.state_q !== ST_PAUSE || running !== 1'b0) begin
            n_err++; $display("FAIL pause_hold: count %h state %0d run %b want 000007 PAUSE 0", dut.count_q, dut.state_q, running);
        end
        n_cmp++;
        if (dut.presc_q !== 2'd1) begin
            n_err++; $display("FAIL pause_presc_hold: got %0d want 1", dut.presc_q);
        end
        pulse(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (dut.state_q !== ST_IDLE || dut.count_q !== 24'h000000 || running !== 1'b0 || dut.presc_q !== 2'd0) begin
            n_err++; $display("FAIL pause_clear: state %0d count %h run %b presc %0d want IDLE 000000 0 0", dut.state_q, dut.count_q, running, dut.presc_q);
        end
        repeat (8) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000000 || disp_all() !== {6{P0}}) begin
            n_err++; $display("FAIL clear_idle_hold: count %h disp %h want 000000 %h", dut.count_q, disp_all(), {6{P0}});
        end
    endtask

    task automatic test_tick_on_stop();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000001 || dut.state_q !== ST_PAUSE) begin
            n_err++; $display("FAIL tick_on_stop: count %h state %0d want 000001 PAUSE", dut.count_q, dut.state_q);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        pulse(1'b0, 1'b1, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_IDLE || running !== 1'b0) begin
            n_err++; $display("FAIL idle_ignore: state %0d run %b want IDLE 0", dut.state_q, running);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_PAUSE) begin
            n_err++; $display("FAIL run_ss_beats_lap: state %0d want PAUSE", dut.state_q);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_PAUSE) begin
            n_err++; $display("FAIL pause_lap_ignored: state %0d want PAUSE", dut.state_q);
        end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_LAP || running !== 1'b1) begin
            n_err++; $display("FAIL enter_lap: state %0d run %b want LAP 1", dut.state_q, running);
        end
        pulse(1'b1, 1'b0, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_PAUSE) begin
            n_err++; $display("FAIL lap_ss_beats_lap: state %0d want PAUSE", dut.state_q);
        end
    endtask

    task automatic test_clear_ignored_and_abort();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (12) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (dut.count_q !== 24'h000004 || dut.state_q !== ST_RUN) begin
            n_err++; $display("FAIL run_clear_ignored: count %h state %0d want 000004 RUN", dut.count_q, dut.state_q);
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (dut.state_q !== ST_LAP || dut.lap_q !== 24'h000004) begin
            n_err++; $display("FAIL lap_capture: state %0d lap %h want LAP 000004", dut.state_q, dut.lap_q);
        end
        reset = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut.state_q !== ST_IDLE || dut.count_q !== 24'h000000 || dut.lap_q !== 24'h000000 || dut.presc_q !== 2'd0) begin
            n_err++; $display("FAIL abort_state: state %0d count %h lap %h presc %0d want IDLE 0 0 0", dut.state_q, dut.count_q, dut.lap_q, dut.presc_q);
        end
        n_cmp++;
        if (running !== 1'b0 || disp_all() !== {6{P0}}) begin
            n_err++; $display("FAIL abort_outputs: run %b disp %h want 0 %h", running, disp_all(), {6{P0}});
        end
        reset = 1'b0;
        start_stop = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        start_stop = 1'b0;
        clear = 1'b0;
        lap = 1'b0;
        @(negedge clk);
        test_reset();
        test_run_basic();
        test_wrap();
        test_lap();
        test_pause_clear();
        test_tick_on_stop();
        test_back_to_back();
        test_clear_ignored_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter TICKS_PER_CS, default 500000: clk cycles per centisecond (50 MHz clk).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start_stop  input  1  single-cycle debounced pulse; toggles run/pause.
REQ-005 clear  input  1  single-cycle debounced pulse; zeroes the count when paused.
REQ-006 lap  input  1  single-cycle debounced pulse; freezes or releases the display while counting continues.
REQ-007 stop_disp0..stop_disp5  output  7 each  registered 7-seg patterns feeding the display mux stopwatch inputs. Digits are: disp0 = centisecond ones, disp1 = centisecond tens, disp2 = second ones, disp3 = second tens, disp4 = minute ones, disp5 = minute tens.
REQ-008 running  output  1  high in RUN or LAP.

Function
REQ-009 Segment encoding SHALL be bit0=a … bit6=g, active-low (0 = lit); digits 0-9 only.
REQ-010 FSM states SHALL be IDLE, RUN, PAUSE and LAP.
REQ-011 IDLE transitions: start_stop -> RUN; clear and lap have no effect.
REQ-012 RUN transitions: start_stop -> PAUSE; otherwise lap -> LAP, capturing the current count into the lap register the same edge.
REQ-013 LAP transitions: start_stop -> PAUSE, with the display reverting to the live count; otherwise lap -> RUN, releasing the frozen display.
REQ-014 PAUSE transitions: clear -> IDLE, zeroing the BCD count and prescaler; otherwise start_stop -> RUN.
REQ-015 Simultaneous pulses: clear SHALL beat start_stop in PAUSE, and start_stop SHALL beat lap in RUN/LAP. Every other input is ignored when not listed.
REQ-016 Prescaler: 0..TICKS_PER_CS-1 counter.
  - Advances only in RUN/LAP; holds in PAUSE.
  - Zeroed in IDLE.
  - Width is clog2(TICKS_PER_CS).
REQ-017 Centisecond increment SHALL occur on the edge where the prescaler equals TICKS_PER_CS-1 in RUN/LAP; the prescaler wraps to 0 on the same edge.
REQ-018 Count SHALL be six BCD digits (4 bits each) with carries:
  - centiseconds 99 -> 00, carrying into seconds;
  - seconds 59 -> 00, carrying into minutes;
  - minutes 59 -> 00.
  - 59:59.99 plus one increment SHALL give 00:00.00, with the FSM staying in RUN/LAP.
REQ-019 Displayed source: the lap register in LAP, otherwise the live count.
REQ-020 stop_disp outputs SHALL be registered and reflect the selected source one clk after it changes.
REQ-021 An increment coinciding with a start_stop that leaves RUN/LAP SHALL still be applied.

Reset
REQ-022 On reset the block SHALL:
  - enter IDLE;
  - clear the count, lap register and prescaler;
  - drive running=0;
  - drive every stop_disp to the pattern for 0 (7'b1000000) on the following edge.
REQ-023 Reset SHALL take precedence over all pulses, and reset asserted mid-RUN or mid-LAP SHALL abort to IDLE in one cycle.

Structure
REQ-024 Shared package stopwatch_pkg SHALL hold:
  - the FSM state encoding;
  - the ten active-low segment constants;
  - the TICKS_PER_CS default;
  - digit limits (9, 5).
REQ-025 A single combinational sub-module bcd_to_seg7 (4-bit BCD in, 7-bit pattern out) SHALL be instantiated six times. Non-BCD inputs produce all segments off (7'b1111111).

Verification (TICKS_PER_CS=4)
REQ-026 Reset, then start_stop, then 40 clk -> running=1; count 00:00.10; stop_disp1=7'b1111001, stop_disp0=7'b1000000.
REQ-027 Preload 59:59.99 in RUN, then one tick -> 00:00.00 with state RUN, and all digits show the 0 pattern one clk later.
REQ-028 Run to 00:00.05, then lap, then run 20 more clk -> display still 00:00.05 while the internal count is 00:00.10. A second lap -> display shows 00:00.10 one clk later.
REQ-029 Pause at 00:00.07, with clear and start_stop in the same cycle -> IDLE; count 00:00.00; running=0.
REQ-030 In RUN, assert clear alone -> ignored, count keeps advancing. Then reset mid-LAP -> IDLE; all outputs at reset values.
